elevator_car_sequencer: RTL and testbench
=========================================

Name: elevator_car_sequencer

Overview:
- Car-side responder to the latched request lamps.
- Consumes the lit status of the 3 car buttons and the 4 hall buttons.
- Moves the car between floors 1-3 with a travel timer and runs a door-dwell timer.
- Returns one-cycle clear pulses to the button latches for each request it services. It is the consumer end of the button set/clear handshake.

Parameters:
TRAVEL_CYCLES, 8, cycles spent moving between adjacent floors (>=1)
DOOR_CYCLES, 6, cycles door stays open per service (>=1)
CNT_W, 8, timer counter width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
elevator_floor_button  input  3  lit car buttons; [2]=floor1, [1]=floor2, [0]=floor3
floor_button  input  4  lit hall buttons; [3]=1up, [2]=2down, [1]=2up, [0]=3down
floor  output  3  one-hot car position; 100=floor1, 010=floor2, 001=floor3
door  output  1  1 = door open
moving  output  1  1 = car travelling
dir_up  output  1  current/last travel direction, 1 = up
elevator_floor_button_clear  output  3  one-cycle clear pulses, same bit mapping as elevator_floor_button
floor_button_clear  output  4  one-cycle clear pulses, same bit mapping as floor_button

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All outputs registered.
- Reset values, applied immediately even mid-move or mid-dwell: state=IDLE, floor=100, door=0, moving=0, dir_up=1, all clears=0, counter=0.
- Request at floor f:
  - floor1: car[2] | hall[3]
  - floor2: car[1] | hall[2] | hall[1]
  - floor3: car[0] | hall[0]
- req_above / req_below: any request at a floor strictly above / below the current floor.
- States: IDLE, OPEN, MOVE_UP, MOVE_DOWN.
- IDLE, evaluated each cycle, first match wins:
  1. Request at current floor -> OPEN.
  2. dir_up & req_above -> MOVE_UP.
  3. req_below -> MOVE_DOWN, dir_up<=0.
  4. req_above -> MOVE_UP, dir_up<=1.
  5. Otherwise stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - moving=1; counter counts TRAVEL_CYCLES cycles.
  - On the expiry edge, floor shifts one position (up: floor>>1, down: floor<<1), then:
    - request at new floor -> OPEN on the same edge (door=1, moving=0, clears pulsed that cycle);
    - else request further in the same direction -> continue moving, counter reloads;
    - else -> IDLE, moving=0.
  - Car never leaves floor1..floor3. MOVE_UP is never entered at floor3, nor MOVE_DOWN at floor1.
- OPEN:
  - door=1; counter counts DOOR_CYCLES cycles.
  - In the entry cycle, clear pulses go to the current floor's car bit and all hall bits at that floor (floor2 clears both [2] and [1]).
  - A new request at the current floor during OPEN restarts the dwell counter and re-pulses the matching clears in the next cycle.
  - On expiry: door=0 and state=IDLE on the same edge.
- Clear pulses:
  - Exactly 1 cycle wide.
  - Never asserted outside the OPEN entry/re-pulse cycle.
  - Never asserted for a floor other than the current floor.
- Door and motion are mutually exclusive: door and moving are never both 1.
- Requests at other floors never interrupt travel or dwell.
- Counter wraps are not permitted: it reloads to 0 on every state entry.

Test Plan:
- Reset: assert rst_n=0 mid-MOVE_UP at cycle 5 -> floor=100, door=0, moving=0, dir_up=1, clears=0 immediately, no further activity with no requests.
- Car button floor3 lit from floor1 (TRAVEL_CYCLES=8, DOOR_CYCLES=6) ->
  - MOVE_UP next edge;
  - floor=010 after 8 cycles with no stop;
  - floor=001 with door=1 and elevator_floor_button_clear=001 after 16 cycles;
  - door=0 after 6 more cycles.
- Hall 1up lit while idle at floor1 -> OPEN next edge, floor_button_clear=1000 for one cycle, door high exactly 6 cycles.
- At floor2 going up, 3down and 1up both lit -> serves floor3 first (dir_up held), then reverses: dir_up=0, MOVE_DOWN to floor1, clears 0001 then 1000.
- During OPEN at floor2, hall 2down lit at dwell cycle 4 -> floor_button_clear=0100 one cycle later, door held 6 cycles from the restart (10 total).
- Car buttons floor1 and floor3 lit simultaneously while idle at floor2 with dir_up=1 -> moves up first, floor=001 before 100.

Source files
------------

// File: rtl/elevator_car_sequencer.sv
// Car-side sequencer: serves lit car/hall requests across floors 1-3, runs the
// travel and door-dwell timers and pulses the button-latch clears for each service.
module elevator_car_sequencer #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 6,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] elevator_floor_button,
    input  logic [3:0] floor_button,
    output logic [2:0] floor,
    output logic       door,
    output logic       moving,
    output logic       dir_up,
    output logic [2:0] elevator_floor_button_clear,
    output logic [3:0] floor_button_clear
);

    typedef enum logic [1:0] {IDLE, OPEN, MOVE_UP, MOVE_DOWN} state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       floor_d, car_clr_d;
    logic [3:0]       hall_clr_d;
    logic             dir_d;

    // Requests folded onto the same one-hot layout as floor: [2]=floor1 .. [0]=floor3.
    logic [2:0] req;
    assign req = {elevator_floor_button[2] | floor_button[3],
                  elevator_floor_button[1] | floor_button[2] | floor_button[1],
                  elevator_floor_button[0] | floor_button[0]};

    function automatic logic [2:0] above_mask(input logic [2:0] f);
        return (f >> 1) | (f >> 2);
    endfunction

    function automatic logic [2:0] below_mask(input logic [2:0] f);
        return (f << 1) | (f << 2);
    endfunction

    function automatic logic [3:0] hall_mask(input logic [2:0] f);
        return {f[2], f[1], f[1], f[0]};
    endfunction

    logic       req_here, req_above, req_below;
    logic [2:0] next_floor;
    logic [2:0] fresh_car;
    logic [3:0] fresh_hall;

    assign req_here   = |(req & floor);
    assign req_above  = |(req & above_mask(floor));
    assign req_below  = |(req & below_mask(floor));
    assign next_floor = (state == MOVE_UP) ? (floor >> 1) : (floor << 1);
    // Only bits not already being cleared this cycle count as new requests during dwell.
    assign fresh_car  = elevator_floor_button & floor & ~elevator_floor_button_clear;
    assign fresh_hall = floor_button & hall_mask(floor) & ~floor_button_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= IDLE;
            cnt                         <= '0;
            floor                       <= 3'b100;
            door                        <= 1'b0;
            moving                      <= 1'b0;
            dir_up                      <= 1'b1;
            elevator_floor_button_clear <= '0;
            floor_button_clear          <= '0;
        end else begin
            state                       <= state_d;
            cnt                         <= cnt_d;
            floor                       <= floor_d;
            door                        <= (state_d == OPEN);
            moving                      <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
            dir_up                      <= dir_d;
            elevator_floor_button_clear <= car_clr_d;
            floor_button_clear          <= hall_clr_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        floor_d    = floor;
        dir_d      = dir_up;
        car_clr_d  = '0;
        hall_clr_d = '0;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (req_here) begin
                    state_d    = OPEN;
                    car_clr_d  = floor;
                    hall_clr_d = hall_mask(floor);
                end else if (dir_up && req_above) begin
                    state_d = MOVE_UP;
                end else if (req_below) begin
                    state_d = MOVE_DOWN;
                    dir_d   = 1'b0;
                end else if (req_above) begin
                    state_d = MOVE_UP;
                    dir_d   = 1'b1;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt == TRAVEL_LAST) begin
                    floor_d = next_floor;
                    cnt_d   = '0;
                    if (|(req & next_floor)) begin
                        state_d    = OPEN;
                        car_clr_d  = next_floor;
                        hall_clr_d = hall_mask(next_floor);
                    end else if (state == MOVE_UP ? |(req & above_mask(next_floor))
                                                  : |(req & below_mask(next_floor))) begin
                        state_d = state;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            OPEN: begin
                if ((|fresh_car) || (|fresh_hall)) begin
                    cnt_d      = '0;
                    car_clr_d  = fresh_car;
                    hall_clr_d = fresh_hall;
                end else if (cnt == DOOR_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_elevator_car_sequencer.sv
// Self-checking bench: button latches and a floor-number/countdown reference model
// of the car, driven by directed scenarios followed by random button presses.
module tb_elevator_car_sequencer;

    localparam int TRAVEL = 8;
    localparam int DWELL  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] car_lit = '0;
    logic [3:0] hall_lit = '0;
    logic [2:0] floor;
    logic       door, moving, dir_up;
    logic [2:0] car_clr;
    logic [3:0] hall_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: floor as 1..3, countdown of remaining cycles.
    int         m_floor;
    bit         m_door, m_moving, m_dir_up;
    int         m_timer;
    logic [2:0] m_car_clr;
    logic [3:0] m_hall_clr;

    elevator_car_sequencer #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DWELL),
        .CNT_W        (8)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .elevator_floor_button      (car_lit),
        .floor_button               (hall_lit),
        .floor                      (floor),
        .door                       (door),
        .moving                     (moving),
        .dir_up                     (dir_up),
        .elevator_floor_button_clear(car_clr),
        .floor_button_clear         (hall_clr)
    );

    always #5 clk = ~clk;

    function automatic bit wants(input int f, input logic [2:0] c, input logic [3:0] h);
        case (f)
            1: return c[2] | h[3];
            2: return c[1] | h[2] | h[1];
            3: return c[0] | h[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit any_above(input int f, input logic [2:0] c, input logic [3:0] h);
        for (int k = f + 1; k <= 3; k++) if (wants(k, c, h)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input int f, input logic [2:0] c, input logic [3:0] h);
        for (int k = 1; k < f; k++) if (wants(k, c, h)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] car_bits(input int f);
        return 3'(1 << (3 - f));
    endfunction

    function automatic logic [3:0] hall_bits(input int f);
        case (f)
            1: return 4'b1000;
            2: return 4'b0110;
            3: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_floor    = 1;
        m_door     = 0;
        m_moving   = 0;
        m_dir_up   = 1;
        m_timer    = 0;
        m_car_clr  = '0;
        m_hall_clr = '0;
    endtask

    task automatic open_here();
        m_door     = 1;
        m_moving   = 0;
        m_timer    = DWELL;
        m_car_clr  = car_bits(m_floor);
        m_hall_clr = hall_bits(m_floor);
    endtask

    task automatic start_trip(input bit up);
        m_moving = 1;
        m_dir_up = up;
        m_timer  = TRAVEL;
    endtask

    task automatic model_step(input logic [2:0] c, input logic [3:0] h);
        logic [2:0] prev_c, fc;
        logic [3:0] prev_h, fh;
        prev_c     = m_car_clr;
        prev_h     = m_hall_clr;
        m_car_clr  = '0;
        m_hall_clr = '0;
        if (m_door) begin
            fc = c & car_bits(m_floor) & ~prev_c;
            fh = h & hall_bits(m_floor) & ~prev_h;
            if ((fc != 0) || (fh != 0)) begin
                m_timer    = DWELL;
                m_car_clr  = fc;
                m_hall_clr = fh;
            end else begin
                m_timer--;
                if (m_timer == 0) m_door = 0;
            end
        end else if (m_moving) begin
            m_timer--;
            if (m_timer == 0) begin
                m_floor += m_dir_up ? 1 : -1;
                if (wants(m_floor, c, h)) open_here();
                else if (m_dir_up ? any_above(m_floor, c, h) : any_below(m_floor, c, h))
                    m_timer = TRAVEL;
                else m_moving = 0;
            end
        end else begin
            if (wants(m_floor, c, h)) open_here();
            else if (m_dir_up && any_above(m_floor, c, h)) start_trip(1);
            else if (any_below(m_floor, c, h)) start_trip(0);
            else if (any_above(m_floor, c, h)) start_trip(1);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        checkOutput("floor", {1'b0, floor}, {1'b0, 3'(4 >> (m_floor - 1))});
        checkOutput("door", {3'b0, door}, {3'b0, m_door});
        checkOutput("moving", {3'b0, moving}, {3'b0, m_moving});
        checkOutput("dir_up", {3'b0, dir_up}, {3'b0, m_dir_up});
        checkOutput("car_clear", {1'b0, car_clr}, {1'b0, m_car_clr});
        checkOutput("hall_clear", hall_clr, m_hall_clr);
        checkOutput("door_and_moving", {3'b0, door & moving}, 4'b0000);
    endtask

    // One clock: model predicts, DUT steps, latches absorb clears then new presses.
    task automatic applyStimulus(input logic [2:0] press_car, input logic [3:0] press_hall);
        logic [2:0] cc;
        logic [3:0] hc;
        model_step(car_lit, hall_lit);
        cc = car_clr;
        hc = hall_clr;
        @(posedge clk);
        #1;
        compare_all();
        car_lit  = (car_lit & ~cc) | press_car;
        hall_lit = (hall_lit & ~hc) | press_hall;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(3'b000, 4'b0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_floor", {1'b0, floor}, 4'b0100);
        checkOutput("rst_door", {3'b0, door}, 4'b0000);
        checkOutput("rst_moving", {3'b0, moving}, 4'b0000);
        checkOutput("rst_dir_up", {3'b0, dir_up}, 4'b0001);
        checkOutput("rst_car_clear", {1'b0, car_clr}, 4'b0000);
        checkOutput("rst_hall_clear", hall_clr, 4'b0000);
        model_reset();
        car_lit  = '0;
        hall_lit = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        idle_cycles(3);

        // Reset in the middle of an upward trip.
        applyStimulus(3'b001, 4'b0000);
        idle_cycles(5);
        do_reset();
        idle_cycles(10);

        // Car call to floor3 from floor1, passing floor2 without stopping.
        applyStimulus(3'b001, 4'b0000);
        idle_cycles(30);

        // Back to floor1, then hall 1up while idle there.
        applyStimulus(3'b100, 4'b0000);
        idle_cycles(30);
        applyStimulus(3'b000, 4'b1000);
        idle_cycles(12);

        // Up to floor2, then 3down and 1up lit during the dwell.
        applyStimulus(3'b010, 4'b0000);
        idle_cycles(12);
        applyStimulus(3'b000, 4'b1001);
        idle_cycles(60);

        // Up to floor2 again; hall 2down lit partway through the dwell.
        applyStimulus(3'b010, 4'b0000);
        idle_cycles(12);
        applyStimulus(3'b000, 4'b0100);
        idle_cycles(15);

        // Idle at floor2 heading up, floor1 and floor3 car calls together.
        applyStimulus(3'b101, 4'b0000);
        idle_cycles(60);

        // Random presses, with one reset dropped in mid-run.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] pc;
            logic [3:0] ph;
            for (int b = 0; b < 3; b++) pc[b] = ($urandom_range(0, 11) == 0);
            for (int b = 0; b < 4; b++) ph[b] = ($urandom_range(0, 11) == 0);
            if (i == 1500) do_reset();
            applyStimulus(pc, ph);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
